mem_xfer_ctrl: RTL and testbench
================================

// Module: mem_xfer_ctrl
// PURPOSE
//  Initiator side of the data-memory port: sequences LDM/STM-style block transfers.
//  Walks a register list and issues one memory access per set bit, driving addr/i/ldr_str_en/load_en/store_en.
//  Moves data between register file and memory. Sits between execute stage and data memory file.
// PARAMETERS
//  ADDR_W  8   memory address / offset width
//  DATA_W  32  data word width
//  NREGS   16  register-list width (one bit per architectural register)
//  REG_AW  4   register-file address width, log2(NREGS)
// PORTS
//  clk             in   1       clock, all state on rising edge
//  rst             in   1       asynchronous, active-low reset
//  start           in   1       request pulse; sampled only in IDLE
//  is_load         in   1       1 = load (mem->rf), 0 = store (rf->mem)
//  base_addr       in   ADDR_W  base address of the block
//  reg_list        in   NREGS   bit r set = transfer register r
//  busy            out  1       high in XFER and DONE
//  done            out  1       one-cycle completion pulse
//  mem_addr        out  ADDR_W  base address to memory
//  mem_i           out  ADDR_W  word offset (transfer index k)
//  mem_ldr_str_en  out  1       memory access enable
//  mem_load_en     out  1       memory read strobe
//  mem_store_en    out  1       memory write strobe
//  mem_write_data  out  DATA_W  store data to memory
//  mem_read_data   in   DATA_W  load data from memory, valid same cycle
//  rf_rd_addr      out  REG_AW  register-file read address (stores)
//  rf_rd_data      in   DATA_W  register-file read data, combinational
//  rf_wr_en        out  1       register-file write enable (loads)
//  rf_wr_addr      out  REG_AW  register-file write address
//  rf_wr_data      out  DATA_W  register-file write data
// BEHAVIOUR
//  - FSM IDLE -> XFER -> DONE -> IDLE. start in IDLE captures base_addr, reg_list (mask), is_load; count=0.
//  - Empty reg_list at start: IDLE -> DONE directly. No memory strobe.
//  - XFER cycle: r = lowest set bit of mask; mem_addr=base, mem_i=count, mem_ldr_str_en=1.
//    Store: rf_rd_addr=r, mem_store_en=1, mem_write_data=rf_rd_data.
//    Load: mem_load_en=1, rf_wr_en=1, rf_wr_addr=r, rf_wr_data=mem_read_data.
//  - Each XFER edge: clear bit r, count++. When the cleared mask is zero: -> DONE.
//  - Latency with N set bits: start at cycle 0, accesses in cycles 1..N, done=1 in cycle N+1, IDLE in N+2.
//  - Strobes and addresses decode from registered state/mask/count only. Data paths are combinational pass-through.
//  - Ascending register order. Lowest register uses lowest offset. base+i wraps modulo 2^ADDR_W.
//  - start while busy is ignored; no queueing. Other inputs are don't-care outside the IDLE capture.
//  - rst low, any time: state=IDLE, mask=0, count=0. Every output is 0 immediately.
//    An aborted transfer gives no done pulse; partial writes stay in memory.
// CONFIGURATION
//  MEM_XFER_WRITEBACK_EN defined: adds outputs wb_en (1) and wb_data (ADDR_W).
//    In the DONE cycle: wb_en=1, wb_data=base+N, modulo 2^ADDR_W. Both reset to 0.
//  Not defined: ports absent, no base update logic.
// STRUCTURE
//  mem_xfer_pkg: state enum {IDLE, XFER, DONE}; default widths as localparams.
//  Sub-module prio_enc_lsb: NREGS-bit lowest-set-bit encoder -> {valid, REG_AW index}.
// TESTING
//  1 STM list=16'h000F, base=8'h10, rf_rd_data=100+addr -> cycles 1..4 store_en, i=0..3, data 100..103; done cycle 5.
//  2 LDM list=16'h8001, base=8'h20, read_data=8'hA0+i -> rf writes r0=A0 (cycle 1), r15=A1 (cycle 2); done cycle 3.
//  3 start, list=16'h0000 -> done cycle 1, busy cycles 1 only, no mem/rf strobe ever.
//  4 start re-pulsed in cycles 2 and 3 of a 4-reg transfer -> ignored; exactly 4 accesses, one done.
//  5 rst low after 2 of 4 stores -> all outputs 0 at once, no done. New STM after release completes normally.
//  6 MEM_XFER_WRITEBACK_EN, base=8'hFE, list=16'h00F0 -> wb_en=1 with wb_data=8'h02 in the done cycle only.

Source files
------------

// File: rtl/mem_xfer_pkg.sv
// Shared types and default widths for the block-transfer controller.
package mem_xfer_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 32;
  localparam int NREGS_DEF  = 16;
  localparam int REG_AW_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/prio_enc_lsb.sv
// Lowest-set-bit priority encoder: reports whether any request bit is set
// and the index of the lowest one.
module prio_enc_lsb #(
  parameter int NREGS  = 16,
  parameter int REG_AW = 4
) (
  input  logic [NREGS-1:0]  req,
  output logic              valid,
  output logic [REG_AW-1:0] idx
);

  logic [NREGS-1:0] onehot;

  // Each bit wins only if nothing below it is set; no ripple chain between bits.
  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_onehot
      if (gi == 0) begin : g_first
        assign onehot[gi] = req[gi];
      end else begin : g_rest
        assign onehot[gi] = req[gi] & ~(|req[gi-1:0]);
      end
    end
  endgenerate

  always_comb begin
    idx = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (onehot[i]) idx = idx | REG_AW'(i);
    end
  end

  assign valid = |req;

endmodule

// File: rtl/mem_xfer_ctrl.sv
// LDM/STM-style block transfer sequencer between register file and data memory.
// Optional MEM_XFER_WRITEBACK_EN adds a base-update output (wb_en/wb_data).
module mem_xfer_ctrl
  import mem_xfer_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int NREGS  = NREGS_DEF,
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              is_load,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [NREGS-1:0]  reg_list,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [ADDR_W-1:0] mem_i,
  output logic              mem_ldr_str_en,
  output logic              mem_load_en,
  output logic              mem_store_en,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic [REG_AW-1:0] rf_rd_addr,
  input  logic [DATA_W-1:0] rf_rd_data,
  output logic              rf_wr_en,
  output logic [REG_AW-1:0] rf_wr_addr,
  output logic [DATA_W-1:0] rf_wr_data
`ifdef MEM_XFER_WRITEBACK_EN
  ,
  output logic              wb_en,
  output logic [ADDR_W-1:0] wb_data
`endif
);

  state_t            state_reg, state_next;
  logic [NREGS-1:0]  mask_reg, mask_next;
  logic [ADDR_W-1:0] count_reg, count_next;
  logic [ADDR_W-1:0] base_reg, base_next;
  logic              is_load_reg, is_load_next;
  logic              pick_valid;
  logic [REG_AW-1:0] pick_idx;
  logic              xfer_active;

  prio_enc_lsb #(
    .NREGS  (NREGS),
    .REG_AW (REG_AW)
  ) u_pick (
    .req   (mask_reg),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= IDLE;
      mask_reg    <= '0;
      count_reg   <= '0;
      base_reg    <= '0;
      is_load_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      mask_reg    <= mask_next;
      count_reg   <= count_next;
      base_reg    <= base_next;
      is_load_reg <= is_load_next;
    end
  end

  assign xfer_active = (state_reg == XFER) && pick_valid;

  always_comb begin
    state_next     = state_reg;
    mask_next      = mask_reg;
    count_next     = count_reg;
    base_next      = base_reg;
    is_load_next   = is_load_reg;
    busy           = (state_reg != IDLE);
    done           = (state_reg == DONE);
    mem_addr       = '0;
    mem_i          = '0;
    mem_ldr_str_en = 1'b0;
    mem_load_en    = 1'b0;
    mem_store_en   = 1'b0;
    mem_write_data = '0;
    rf_rd_addr     = '0;
    rf_wr_en       = 1'b0;
    rf_wr_addr     = '0;
    rf_wr_data     = '0;

    unique case (state_reg)
      IDLE: begin
        if (start) begin
          mask_next    = reg_list;
          base_next    = base_addr;
          is_load_next = is_load;
          count_next   = '0;
          state_next   = (reg_list == '0) ? DONE : XFER;
        end
      end
      XFER: begin
        mask_next  = mask_reg & ~(NREGS'(1) << pick_idx);
        count_next = count_reg + ADDR_W'(1);
        if (mask_next == '0) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase

    // Data paths pass straight through, but only while an access is live.
    if (xfer_active) begin
      mem_addr       = base_reg;
      mem_i          = count_reg;
      mem_ldr_str_en = 1'b1;
      if (is_load_reg) begin
        mem_load_en = 1'b1;
        rf_wr_en    = 1'b1;
        rf_wr_addr  = pick_idx;
        rf_wr_data  = mem_read_data;
      end else begin
        mem_store_en   = 1'b1;
        rf_rd_addr     = pick_idx;
        mem_write_data = rf_rd_data;
      end
    end
  end

`ifdef MEM_XFER_WRITEBACK_EN
  // count_reg holds the number of transfers once DONE is reached.
  assign wb_en   = (state_reg == DONE);
  assign wb_data = (state_reg == DONE) ? (base_reg + count_reg) : '0;
`endif

endmodule

// File: tb/tb_mem_xfer_ctrl.sv
// Self-checking bench for mem_xfer_ctrl: directed scenarios plus random
// transfers against a transaction-level model of memory and register file.
module tb_mem_xfer_ctrl;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
  localparam int NREGS  = 16;
  localparam int REG_AW = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start, is_load;
  logic [ADDR_W-1:0] base_addr;
  logic [NREGS-1:0]  reg_list;
  logic              busy, done;
  logic [ADDR_W-1:0] mem_addr, mem_i;
  logic              mem_ldr_str_en, mem_load_en, mem_store_en;
  logic [DATA_W-1:0] mem_write_data, mem_read_data;
  logic [REG_AW-1:0] rf_rd_addr;
  logic [DATA_W-1:0] rf_rd_data;
  logic              rf_wr_en;
  logic [REG_AW-1:0] rf_wr_addr;
  logic [DATA_W-1:0] rf_wr_data;
`ifdef MEM_XFER_WRITEBACK_EN
  logic              wb_en;
  logic [ADDR_W-1:0] wb_data;
`endif

  always #5 clk = ~clk;

  mem_xfer_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NREGS(NREGS), .REG_AW(REG_AW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .is_load(is_load),
    .base_addr(base_addr), .reg_list(reg_list), .busy(busy), .done(done),
    .mem_addr(mem_addr), .mem_i(mem_i), .mem_ldr_str_en(mem_ldr_str_en),
    .mem_load_en(mem_load_en), .mem_store_en(mem_store_en),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data),
    .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data), .rf_wr_en(rf_wr_en),
    .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data)
`ifdef MEM_XFER_WRITEBACK_EN
    , .wb_en(wb_en), .wb_data(wb_data)
`endif
  );

  // Memory and register file models serving the DUT's combinational reads.
  logic [DATA_W-1:0] mem_arr [256];
  logic [DATA_W-1:0] rf_arr  [NREGS];
  logic [ADDR_W-1:0] mem_ix;
  assign mem_ix        = mem_addr + mem_i;
  assign mem_read_data = mem_arr[mem_ix];
  assign rf_rd_data    = rf_arr[rf_rd_addr];

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctrl"}, {34'b0, busy, done, mem_addr, mem_i, mem_ldr_str_en, mem_load_en,
                           mem_store_en, rf_rd_addr, rf_wr_en, rf_wr_addr}, 64'd0);
    check({tag, "_data"}, {mem_write_data, rf_wr_data}, 64'd0);
`ifdef MEM_XFER_WRITEBACK_EN
    check({tag, "_wb"}, {wb_en, wb_data}, 64'd0);
`endif
  endtask

  // One transfer: start in cycle 0, accesses in 1..N, done in N+1, idle in N+2.
  task automatic run_xfer(input bit ld, input logic [7:0] base, input logic [15:0] list,
                          input bit repulse);
    int regs[$];
    int n, r;
    logic [7:0] ea;
    for (int i = 0; i < NREGS; i++) if (list[i]) regs.push_back(i);
    n = regs.size();
    $display("xfer load=%0d base=%02h list=%04h n=%0d repulse=%0d", ld, base, list, n, repulse);
    @(negedge clk);
    start = 1'b1; is_load = ld; base_addr = base; reg_list = list;
    for (int k = 1; k <= n + 2; k++) begin
      @(negedge clk);
      if (k <= n) begin
        r  = regs[k-1];
        ea = 8'(int'(base) + k - 1);
        check("busy_x", busy, 1);
        check("done_x", done, 0);
        check("strobes_x", {mem_ldr_str_en, mem_load_en, mem_store_en, rf_wr_en},
              {1'b1, ld, !ld, ld});
        check("mem_addr", mem_addr, base);
        check("mem_i", mem_i, k - 1);
        if (ld) begin
          check("rf_wr_addr", rf_wr_addr, r);
          check("rf_wr_data", rf_wr_data, mem_arr[ea]);
          rf_arr[r] = mem_arr[ea];
        end else begin
          check("rf_rd_addr", rf_rd_addr, r);
          check("mem_write_data", mem_write_data, rf_arr[r]);
          mem_arr[ea] = rf_arr[r];
        end
`ifdef MEM_XFER_WRITEBACK_EN
        check("wb_en_x", wb_en, 0);
`endif
      end else if (k == n + 1) begin
        check("busy_d", busy, 1);
        check("done_d", done, 1);
        check("strobes_d", {mem_ldr_str_en, mem_load_en, mem_store_en, rf_wr_en}, 0);
`ifdef MEM_XFER_WRITEBACK_EN
        check("wb", {wb_en, wb_data}, {1'b1, 8'(int'(base) + n)});
`endif
      end else begin
        check("busy_i", busy, 0);
        check("done_i", done, 0);
        check("strobes_i", {mem_ldr_str_en, mem_load_en, mem_store_en, rf_wr_en}, 0);
      end
      // Inputs are don't-care after capture; scramble them to prove they are not reused.
      start     = (repulse && (k == 2 || k == 3)) ? 1'b1 : 1'b0;
      is_load   = 1'($urandom);
      base_addr = 8'($urandom);
      reg_list  = 16'($urandom);
    end
    start = 1'b0;
  endtask

  // Store of four registers aborted by reset after two accesses.
  task automatic reset_mid();
    $display("xfer abort load=0 base=40 list=000f after 2 accesses");
    @(negedge clk);
    start = 1'b1; is_load = 1'b0; base_addr = 8'h40; reg_list = 16'h000F;
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      start = 1'b0;
      check("abort_store_en", mem_store_en, 1);
      check("abort_mem_i", mem_i, k - 1);
    end
    @(negedge clk);
    #2 rst = 1'b0;
    #1 check_all_zero("abort_rst");
    repeat (3) begin
      @(negedge clk);
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
    end
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check_all_zero("abort_after");
    end
  endtask

  initial begin
    bit         ld, rp;
    logic [7:0] b;
    logic [15:0] l;
    start = 1'b0; is_load = 1'b0; base_addr = '0; reg_list = '0;
    for (int i = 0; i < 256; i++) mem_arr[i] = $urandom;
    for (int i = 0; i < NREGS; i++) rf_arr[i] = $urandom;

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("post_reset");

    for (int i = 0; i < NREGS; i++) rf_arr[i] = 100 + i;
    run_xfer(1'b0, 8'h10, 16'h000F, 1'b0);
    for (int i = 0; i < 4; i++) check("stm_mem", mem_arr[8'h10 + i], 100 + i);

    for (int i = 0; i < 4; i++) mem_arr[8'h20 + i] = 32'hA0 + i;
    run_xfer(1'b1, 8'h20, 16'h8001, 1'b0);
    check("ldm_r0", rf_arr[0], 32'hA0);
    check("ldm_r15", rf_arr[15], 32'hA1);

    run_xfer(1'b0, 8'h33, 16'h0000, 1'b0);
    run_xfer(1'b0, 8'h50, 16'h1248, 1'b1);

    reset_mid();
    run_xfer(1'b0, 8'h40, 16'h000F, 1'b0);

    run_xfer(1'b0, 8'hFE, 16'h00F0, 1'b0);
    run_xfer(1'b1, 8'hFD, 16'hFFFF, 1'b0);

    for (int t = 0; t < 24; t++) begin
      ld = 1'($urandom);
      b  = 8'($urandom);
      case ($urandom_range(0, 3))
        0:       l = 16'h0000;
        1:       l = 16'(1) << $urandom_range(0, 15);
        default: l = 16'($urandom);
      endcase
      rp = ($countones(l) >= 2) ? 1'($urandom) : 1'b0;
      run_xfer(ld, b, l, rp);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
